// File: rtl/alarm_pkg.sv
// Shared constants and helpers for the alarm sounder slice.
package alarm_pkg;

  // FSM state encodings, kept as plain constants for legacy tooling.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRing  = 2'd1;
  localparam logic [1:0] StQuiet = 2'd2;

  // Clock cycles per half tone period.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

endpackage

// File: rtl/alarm_sounder_tone_gen.sv
// Square-wave divider: toggles tone every HALF_PERIOD cycles while enabled.
module tone_gen #(
  parameter int unsigned HALF_PERIOD = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tone
);

  localparam int unsigned CntW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(HALF_PERIOD - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            tone_d, tone_q;

  // Next-state: count 0..HALF_PERIOD-1, toggle on wrap, clear while disabled.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (!en) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == CntMax) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/alarm_sounder.sv
// Alarm sounder: detects the alarm minute at second 00 and rings a gated tone.
module alarm_sounder
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned TONE_HZ      = 1000,
  parameter int unsigned RING_SECONDS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_sec,
  input  logic [2:0] minutes_tens,
  input  logic [3:0] minutes_ones,
  input  logic [2:0] seconds_tens,
  input  logic [3:0] seconds_ones,
  input  logic [2:0] alarm_min_tens,
  input  logic [3:0] alarm_min_ones,
  input  logic       alarm_off,
  input  logic       load,
  output logic       audio_out,
  output logic       aud_sd,
  output logic       ringing
);

  localparam int unsigned HALF_PERIOD = half_period(CLK_HZ, TONE_HZ);
  localparam int unsigned RingW = (RING_SECONDS > 0) ? $clog2(RING_SECONDS + 1) : 1;
  localparam logic [RingW-1:0] RingMax = RingW'(RING_SECONDS);

  logic [1:0]       state_d, state_q;
  logic [RingW-1:0] ring_cnt_d, ring_cnt_q;
  logic             gate_d, gate_q;
  logic             match, match_q, trig, exit_ring, in_ring, tone;
  logic             audio_out_d, audio_out_q;
  logic             aud_sd_d, aud_sd_q;
  logic             ringing_d, ringing_q;

  assign match = (minutes_tens == alarm_min_tens) && (minutes_ones == alarm_min_ones) &&
                 (seconds_tens == 3'd0) && (seconds_ones == 4'd0);

  // Rising edge only, so a match held static never re-arms.
  assign trig      = match & ~match_q & ~alarm_off & ~load;
  assign exit_ring = alarm_off | load | (ring_cnt_q == RingMax);
  assign in_ring   = (state_q == StRing);

  // FSM next-state plus ring counter and beep gate; exit beats a coincident tick.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = '0;
    gate_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (trig) begin
          state_d = StRing;
          gate_d  = 1'b1;
        end
      end
      StRing: begin
        ring_cnt_d = ring_cnt_q;
        gate_d     = gate_q;
        if (exit_ring) begin
          state_d    = StQuiet;
          ring_cnt_d = '0;
          gate_d     = 1'b0;
        end else if (tick_sec) begin
          ring_cnt_d = ring_cnt_q + RingW'(1);
          gate_d     = ~gate_q;
        end
      end
      StQuiet: begin
        if (!match) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output register inputs, derived from the current state.
  always_comb begin
    audio_out_d = in_ring & gate_q & tone;
    aud_sd_d    = in_ring;
    ringing_d   = in_ring;
  end

  // State, edge-detect and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      match_q     <= 1'b0;
      ring_cnt_q  <= '0;
      gate_q      <= 1'b0;
      audio_out_q <= 1'b0;
      aud_sd_q    <= 1'b0;
      ringing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match;
      ring_cnt_q  <= ring_cnt_d;
      gate_q      <= gate_d;
      audio_out_q <= audio_out_d;
      aud_sd_q    <= aud_sd_d;
      ringing_q   <= ringing_d;
    end
  end

  tone_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_tone_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (in_ring),
    .tone  (tone)
  );

  assign audio_out = audio_out_q;
  assign aud_sd    = aud_sd_q;
  assign ringing   = ringing_q;

endmodule
